// File: rtl/ram_arbiter_d0.sv
// ram_arbiter_d0: two-requester round-robin arbiter in front of one
// synchronous-read RAM (registered read address, 1-cycle read latency).
// A burst limit (MAXBURST) bounds how long one requester may keep the RAM
// while the other one is waiting.
// Optional transfer/wait statistics are built when RAM_ARB_STATS_EN is defined.
module ram_arbiter_d0 #(
  parameter int AWIDTH   = 3,
  parameter int DWIDTH   = 32,
  parameter int MAXBURST = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_a,
  input  logic              we_a,
  input  logic [AWIDTH-1:0] addr_a,
  input  logic [DWIDTH-1:0] din_a,
  output logic              gnt_a,
  output logic              rvalid_a,
  output logic [DWIDTH-1:0] rdata_a,
  input  logic              req_b,
  input  logic              we_b,
  input  logic [AWIDTH-1:0] addr_b,
  input  logic [DWIDTH-1:0] din_b,
  output logic              gnt_b,
  output logic              rvalid_b,
  output logic [DWIDTH-1:0] rdata_b,
  output logic [AWIDTH-1:0] ram_addr,
  output logic [DWIDTH-1:0] ram_din,
  output logic              ram_we,
  input  logic [DWIDTH-1:0] ram_dout
`ifdef RAM_ARB_STATS_EN
  ,
  output logic [15:0]       stat_gnt_a,
  output logic [15:0]       stat_gnt_b,
  output logic [3:0]        stat_wait_max
`endif
);

  typedef enum logic [1:0] {OWN_NONE, OWN_A, OWN_B} owner_e;
  typedef enum logic       {PRIO_A, PRIO_B}         prio_e;

  // Last burst count value before the other requester is forced in.
  localparam logic [3:0] BURST_LAST = 4'(MAXBURST - 1);

  owner_e     r_owner, w_owner_nxt;
  prio_e      r_prio,  w_prio_nxt;
  logic [3:0] r_burst_cnt, w_burst_cnt_nxt;
  logic       r_rvalid_a, r_rvalid_b;
  logic       w_gnt_a, w_gnt_b;

  // State register: owner, burst counter, tie priority and read-valid strobes.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_owner     <= OWN_NONE;
      r_burst_cnt <= '0;
      r_prio      <= PRIO_A;
      r_rvalid_a  <= 1'b0;
      r_rvalid_b  <= 1'b0;
    end else begin
      r_owner     <= w_owner_nxt;
      r_burst_cnt <= w_burst_cnt_nxt;
      r_prio      <= w_prio_nxt;
      r_rvalid_a  <= w_gnt_a & ~we_a;
      r_rvalid_b  <= w_gnt_b & ~we_b;
    end
  end

  // Next-state: extend the burst, hand over to a new owner, or fall idle.
  // NOTE: every combinational output gets a default first so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_owner_nxt     = OWN_NONE;
    w_burst_cnt_nxt = '0;
    w_prio_nxt      = r_prio;
    if (w_gnt_a) begin
      w_owner_nxt = OWN_A;
      if (r_owner == OWN_A) begin
        w_burst_cnt_nxt = (r_burst_cnt >= BURST_LAST) ? BURST_LAST : r_burst_cnt + 4'd1;
      end else begin
        w_prio_nxt = PRIO_B;
      end
    end else if (w_gnt_b) begin
      w_owner_nxt = OWN_B;
      if (r_owner == OWN_B) begin
        w_burst_cnt_nxt = (r_burst_cnt >= BURST_LAST) ? BURST_LAST : r_burst_cnt + 4'd1;
      end else begin
        w_prio_nxt = PRIO_A;
      end
    end
  end

  // Output decode: grant selection from owner, burst count and this cycle's
  // requests; nothing is granted while reset is asserted.
  always_comb begin
    w_gnt_a = 1'b0;
    w_gnt_b = 1'b0;
    if (!reset) begin
      unique case (r_owner)
        OWN_A: begin
          if (req_a && !(req_b && r_burst_cnt >= BURST_LAST)) w_gnt_a = 1'b1;
          else if (req_b)                                     w_gnt_b = 1'b1;
        end
        OWN_B: begin
          if (req_b && !(req_a && r_burst_cnt >= BURST_LAST)) w_gnt_b = 1'b1;
          else if (req_a)                                     w_gnt_a = 1'b1;
        end
        default: begin
          if (req_a && req_b) begin
            w_gnt_a = (r_prio == PRIO_A);
            w_gnt_b = (r_prio == PRIO_B);
          end else begin
            w_gnt_a = req_a;
            w_gnt_b = req_b;
          end
        end
      endcase
    end
  end

  // RAM side mux: A's address/data unless B is granted; write only on a grant.
  assign ram_addr = w_gnt_b ? addr_b : addr_a;
  assign ram_din  = w_gnt_b ? din_b  : din_a;
  assign ram_we   = (w_gnt_a & we_a) | (w_gnt_b & we_b);

  assign gnt_a    = w_gnt_a;
  assign gnt_b    = w_gnt_b;
  assign rvalid_a = r_rvalid_a;
  assign rvalid_b = r_rvalid_b;
  // RAM output already lags the address by one cycle, matching rvalid.
  assign rdata_a  = ram_dout;
  assign rdata_b  = ram_dout;

`ifdef RAM_ARB_STATS_EN
  logic [15:0] r_stat_gnt_a, r_stat_gnt_b;
  logic [3:0]  r_wait_a, r_wait_b, r_wait_max;
  logic [3:0]  w_wait_a_nxt, w_wait_b_nxt, w_wait_peak;

  // Current wait-run lengths after this cycle, saturating at 15.
  always_comb begin
    w_wait_a_nxt = '0;
    w_wait_b_nxt = '0;
    if (req_a && !w_gnt_a) w_wait_a_nxt = (r_wait_a == 4'hF) ? 4'hF : r_wait_a + 4'd1;
    if (req_b && !w_gnt_b) w_wait_b_nxt = (r_wait_b == 4'hF) ? 4'hF : r_wait_b + 4'd1;
    w_wait_peak = (w_wait_a_nxt > w_wait_b_nxt) ? w_wait_a_nxt : w_wait_b_nxt;
  end

  // Statistics registers: saturating transfer counts and longest wait run.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_stat_gnt_a <= '0;
      r_stat_gnt_b <= '0;
      r_wait_a     <= '0;
      r_wait_b     <= '0;
      r_wait_max   <= '0;
    end else begin
      if (w_gnt_a && r_stat_gnt_a != 16'hFFFF) r_stat_gnt_a <= r_stat_gnt_a + 16'd1;
      if (w_gnt_b && r_stat_gnt_b != 16'hFFFF) r_stat_gnt_b <= r_stat_gnt_b + 16'd1;
      r_wait_a <= w_wait_a_nxt;
      r_wait_b <= w_wait_b_nxt;
      if (w_wait_peak > r_wait_max) r_wait_max <= w_wait_peak;
    end
  end

  assign stat_gnt_a    = r_stat_gnt_a;
  assign stat_gnt_b    = r_stat_gnt_b;
  assign stat_wait_max = r_wait_max;
`endif

endmodule

// File: tb/tb_ram_arbiter_d0.sv
// Testbench for ram_arbiter_d0: directed stimulus, read data checked by a
// queue scoreboard drained by a monitor on every rvalid pulse.
module tb_ram_arbiter_d0;

  localparam int AW = 3;
  localparam int DW = 32;

  logic          clock = 1'b0;
  logic          reset;
  logic          req_a, we_a, req_b, we_b;
  logic [AW-1:0] addr_a, addr_b;
  logic [DW-1:0] din_a, din_b;
  logic          gnt_a, gnt_b, rvalid_a, rvalid_b;
  logic [DW-1:0] rdata_a, rdata_b;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic          ram_we;
  logic [DW-1:0] ram_dout;
`ifdef RAM_ARB_STATS_EN
  logic [15:0]   stat_gnt_a, stat_gnt_b;
  logic [3:0]    stat_wait_max;
`endif

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] q_a[$];
  logic [DW-1:0] q_b[$];
  logic [DW-1:0] mdl[8];

  // Synchronous-read RAM: registered read address, write at the edge.
  logic [DW-1:0] ram_mem[8];
  logic [AW-1:0] ram_raddr = '0;

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (ram_we) ram_mem[ram_addr] <= ram_din;
    ram_raddr <= ram_addr;
  end
  assign ram_dout = ram_mem[ram_raddr];

  ram_arbiter_d0 #(.AWIDTH(AW), .DWIDTH(DW), .MAXBURST(4)) dut (
    .clock(clock), .reset(reset),
    .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .din_a(din_a),
    .gnt_a(gnt_a), .rvalid_a(rvalid_a), .rdata_a(rdata_a),
    .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .din_b(din_b),
    .gnt_b(gnt_b), .rvalid_b(rvalid_b), .rdata_b(rdata_b),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout)
`ifdef RAM_ARB_STATS_EN
    , .stat_gnt_a(stat_gnt_a), .stat_gnt_b(stat_gnt_b), .stat_wait_max(stat_wait_max)
`endif
  );

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every rvalid pulse must match the oldest expected read.
  always @(negedge clock) begin
    if (rvalid_a) begin
      if (q_a.size() == 0) check("rvalid_a_unexpected", 1, 0);
      else                 check("rdata_a", rdata_a, q_a.pop_front());
    end
    if (rvalid_b) begin
      if (q_b.size() == 0) check("rvalid_b_unexpected", 1, 0);
      else                 check("rdata_b", rdata_b, q_b.pop_front());
    end
  end

  // One cycle of stimulus with the hand-computed grant for this cycle.
  task automatic cyc(input logic ra, input logic wa, input logic [AW-1:0] aa, input logic [DW-1:0] da,
                     input logic rb, input logic wb, input logic [AW-1:0] ab, input logic [DW-1:0] db,
                     input logic ega, input logic egb, input string tag);
    @(posedge clock);
    #1;
    req_a = ra; we_a = wa; addr_a = aa; din_a = da;
    req_b = rb; we_b = wb; addr_b = ab; din_b = db;
    if (ega && !wa) q_a.push_back(mdl[aa]);
    if (egb && !wb) q_b.push_back(mdl[ab]);
    if (ega && wa)  mdl[aa] = da;
    if (egb && wb)  mdl[ab] = db;
    @(negedge clock);
    check({tag, "_gnt_a"}, 32'(gnt_a), 32'(ega));
    check({tag, "_gnt_b"}, 32'(gnt_b), 32'(egb));
    check({tag, "_ram_we"}, 32'(ram_we), 32'((ega & wa) | (egb & wb)));
    if (ega || egb) check({tag, "_ram_addr"}, 32'(ram_addr), 32'(egb ? ab : aa));
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "idle");
  endtask

  task automatic do_reset();
    @(posedge clock);
    #1;
    reset = 1'b1;
    req_a = 0; we_a = 0; req_b = 0; we_b = 0;
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      ram_mem[i] = '0;
      mdl[i]     = '0;
    end
    reset = 1'b1;
    req_a = 1; we_a = 1; addr_a = 3'd1; din_a = 32'hAAAA_5555;
    req_b = 1; we_b = 1; addr_b = 3'd2; din_b = 32'h5555_AAAA;
    @(negedge clock);
    check("rst_gnt_a", 32'(gnt_a), 0);
    check("rst_gnt_b", 32'(gnt_b), 0);
    check("rst_ram_we", 32'(ram_we), 0);
    check("rst_rvalid_a", 32'(rvalid_a), 0);
    check("rst_rvalid_b", 32'(rvalid_b), 0);
    req_a = 0; we_a = 0; req_b = 0; we_b = 0;
    reset = 1'b0;

    // Single requester: write then read back the same address.
    cyc(1, 1, 3, 32'hDEADBEEF, 0, 0, 0, 0, 1, 0, "t1_wr");
    cyc(1, 0, 3, 0,            0, 0, 0, 0, 1, 0, "t1_rd");
    idle();
    check("t1_model", mdl[3], 32'hDEADBEEF);

    // Tie from idle, both reading, MAXBURST=4: A x4, B x4, A x2.
    do_reset();
    for (int i = 0; i < 10; i++)
      cyc(1, 0, 3, 0, 1, 0, 5, 0, (i < 4 || i >= 8), (i >= 4 && i < 8), "t2_tie");
    idle();
`ifdef RAM_ARB_STATS_EN
    check("stat_gnt_a", 32'(stat_gnt_a), 6);
    check("stat_gnt_b", 32'(stat_gnt_b), 4);
    check("stat_wait_max", 32'(stat_wait_max), 4);
`endif

    // Owner drops its request: B takes over next cycle with a fresh burst.
    cyc(1, 0, 3, 0, 0, 0, 5, 0, 1, 0, "t3_a_only");
    cyc(1, 0, 3, 0, 1, 0, 5, 0, 1, 0, "t3_a_keep");
    cyc(0, 0, 3, 0, 1, 0, 5, 0, 0, 1, "t3_switch");
    for (int i = 0; i < 3; i++) cyc(1, 0, 3, 0, 1, 0, 5, 0, 0, 1, "t3_b_burst");
    cyc(1, 0, 3, 0, 1, 0, 5, 0, 1, 0, "t3_forced");
    idle();
    cyc(1, 0, 3, 0, 1, 0, 5, 0, 0, 1, "t3_prio_b");
    idle();
    cyc(0, 0, 3, 0, 1, 0, 5, 0, 0, 1, "t3_b_only");
    idle();
    cyc(1, 0, 3, 0, 1, 0, 5, 0, 1, 0, "t3_prio_a");
    idle();

    // Write by B, read by A of the same address in the next cycle.
    cyc(0, 0, 0, 0, 1, 1, 5, 32'h0000_1234, 0, 1, "t4_b_wr");
    cyc(1, 0, 5, 0, 0, 0, 0, 0,             1, 0, "t4_a_rd");
    idle();
    check("t4_model", mdl[5], 32'h0000_1234);

    // Read followed by a write to the same address: read sees old data.
    cyc(1, 0, 3, 0, 0, 0, 0, 0,             1, 0, "t4_rd_old");
    cyc(0, 0, 0, 0, 1, 1, 3, 32'hCAFE_F00D, 0, 1, "t4_wr_after");
    idle();

    // Async reset during back-to-back A reads.
    for (int i = 0; i < 3; i++) cyc(1, 0, 3, 0, 0, 0, 0, 0, 1, 0, "t5_rd");
    @(posedge clock);
    #2;
    reset = 1'b1;
    we_a = 1; din_a = 32'hFFFF_FFFF;
    #1;
    check("t5_rvalid_a_cleared", 32'(rvalid_a), 0);
    check("t5_gnt_a_in_reset", 32'(gnt_a), 0);
    check("t5_ram_we_in_reset", 32'(ram_we), 0);
    q_a.delete();
    @(posedge clock);
    #1;
    check("t5_gnt_a_held", 32'(gnt_a), 0);
    check("t5_ram_we_held", 32'(ram_we), 0);
    @(negedge clock);
    req_a = 1; we_a = 0; addr_a = 3;
    req_b = 1; we_b = 0; addr_b = 5;
    reset = 1'b0;
    #1;
    check("t5_first_gnt_a", 32'(gnt_a), 1);
    check("t5_first_gnt_b", 32'(gnt_b), 0);
    q_a.push_back(mdl[3]);
    idle();
    cyc(1, 0, 3, 0, 0, 0, 0, 0, 1, 0, "t5_no_write");
    idle();
    idle();

    check("q_a_drained", 32'(q_a.size()), 0);
    check("q_b_drained", 32'(q_b.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
